ex_stage_md: RTL
================

Name: ex_stage_md

Overview:
- Parametrised execute stage: XLEN-wide integer ALU, operand forwarding, branch/jump resolution, and an RV32M/RV64M multiply/divide unit.
- Sits between the ID/EX and EX/MEM pipeline registers and owns the EX/MEM register.
- Multi-cycle M operations freeze the front of the pipe through stall_req and insert bubbles into EX/MEM until the result is ready.

Parameters:
XLEN, 32, datapath width (32 or 64)
MUL_ITERATIVE, 0, 0 = single-cycle multiply with no stall; 1 = radix-2 shift-add multiply over XLEN cycles
FWD_EN, 1, 0 = forwarding disabled, register-file operands always used

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
in_valid  in  1  ID/EX entry holds a real instruction
flush  in  1  kill the instruction in EX, including an in-flight M operation
id_pc  in  XLEN  PC of the instruction
id_rs1, id_rs2  in  5  source register indices
id_rs1_data, id_rs2_data  in  XLEN  register-file operands
id_imm  in  XLEN  sign-extended immediate
id_rd  in  5  destination register
id_alu_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
id_alu_src  in  1  ALU operand B = id_imm
id_pc_src  in  1  ALU operand A = id_pc (AUIPC)
id_branch, id_jal, id_jalr  in  1 each  control-flow class
id_funct3  in  3  branch condition or M operation
id_md_en  in  1  M-extension instruction
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits passed to EX/MEM
exm_rd  in  5  EX/MEM destination register
exm_reg_write  in  1  EX/MEM write enable
exm_result  in  XLEN  EX/MEM result
wb_rd  in  5  MEM/WB destination register
wb_reg_write  in  1  MEM/WB write enable
wb_data  in  XLEN  MEM/WB write-back data
stall_req  out  1  hold PC, IF/ID and ID/EX stable
take_branch  out  1  redirect fetch
branch_target  out  XLEN  redirect address
ex_valid  out  1  EX/MEM entry valid
ex_result  out  XLEN  EX/MEM result
ex_rs2_data  out  XLEN  EX/MEM store data
ex_rd  out  5  EX/MEM destination register
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  EX/MEM control bits

Behaviour:
- Reset: all EX/MEM outputs 0, FSM to IDLE. stall_req, take_branch and branch_target are 0 while reset is asserted.
- Forwarding, per operand:
  - Use exm_result if exm_reg_write and exm_rd == rs and rs != 0.
  - Else use wb_data if wb_reg_write and wb_rd == rs and rs != 0.
  - Else use the register-file value.
  - EX/MEM has priority over MEM/WB.
- ALU: A = id_pc_src ? id_pc : fwd_rs1; B = id_alu_src ? id_imm : fwd_rs2.
  - Shift amount is B[log2(XLEN)-1:0].
  - SLT is signed and SLTU unsigned; results are zero-extended to XLEN.
- Branch/jump resolution (combinational, only when in_valid && !flush && FSM == IDLE):
  - The comparator is separate from the ALU and compares fwd_rs1 against fwd_rs2.
  - funct3 conditions: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. Other funct3 values never take.
  - Targets: branch and jal = id_pc + id_imm; jalr = (fwd_rs1 + id_imm) & ~1.
  - take_branch is 1 for jal/jalr, and for a branch whose condition holds.
  - A jump writes id_pc + 4 to ex_result.
  - branch_target = 0 when take_branch = 0.
- M unit, funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, multi-cycle op arrives (in_valid && id_md_en, and the op is a divide or MUL_ITERATIVE = 1):
    - Capture forwarded operands and id_rd/control; set stall_req = 1 combinationally in this accept cycle A.
    - Go to BUSY with iteration counter = XLEN.
  - BUSY: one iteration per cycle with stall_req = 1; at count 0 go to DONE.
  - DONE: stall_req = 0; the captured result is loaded into EX/MEM at the end of this cycle; go to IDLE.
    - The repeated in_valid of the same held instruction is not re-accepted.
  - Normal latency: stall_req is high for cycles A..A+XLEN (XLEN+1 cycles); the result reaches ex_result after the edge ending cycle A+XLEN+1.
  - Divide special cases skip BUSY and go A -> DONE (one stall cycle):
    - Divisor 0: quotient all-ones, remainder = dividend.
    - Signed most-negative / -1: quotient = dividend, remainder 0.
  - Single-cycle multiply (MUL_ITERATIVE = 0): no stall; behaves like an ALU op.
  - Signed results use magnitude operations with sign correction; MULH variants return product bits [2*XLEN-1:XLEN].
- EX/MEM loading:
  - Bubble (ex_valid = 0, all control bits 0) while stall_req = 1, when in_valid = 0, or when flush = 1.
  - Otherwise load the result and pass-through fields; ex_rs2_data = fwd_rs2.
- Flush mid-operation: FSM returns to IDLE on the next edge, stall_req drops immediately (combinationally), and no result is ever written.
- Forwarding-source changes during BUSY are ignored because operands were captured in cycle A.

Test Plan:
- EX/MEM and MEM/WB both write x5: EX/MEM = 11, MEM/WB = 22; ADD x6 = x5 + x0 -> ex_result 11. With exm_rd = 0 instead -> 22. With both writes targeting x0 -> register-file value.
- DIVU 100 / 7 with XLEN = 32 -> stall_req high exactly 33 cycles; ex_result 14; ex_valid 0 during the stall, 1 once; REMU of the same operands -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF after 1 stall cycle; REM 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000, REM -> 0.
- flush asserted at cycle A+10 of a DIV -> stall_req 0 the same cycle; no ex_valid for that instruction; a following ADD completes normally.
- BLT with x1 = -3 forwarded from EX/MEM, x2 = 2, pc 0x100, imm 0x20 -> take_branch 1, target 0x120. BLTU with the same operands -> take_branch 0.
- JALR with rs1 = 0x203, imm 0 -> target 0x202, ex_result = pc + 4. MULH 0xFFFFFFFF x 0xFFFFFFFF with MUL_ITERATIVE = 1 -> 0 after 33 stall cycles; MULHU of the same operands -> 0xFFFFFFFE.

Source files
------------

// File: rtl/ex_stage_md.sv
// Execute stage: integer ALU, operand forwarding, branch/jump resolution and
// an M-extension unit. Iterative operations run in a small FSM that freezes
// the front of the pipe and inserts bubbles into the EX/MEM register.
// Handshake: stall_req asks upstream to hold PC, IF/ID and ID/EX stable. An
// ID/EX entry is consumed on a rising edge when in_valid=1, flush=0 and
// stall_req=0. A multi-cycle op is consumed when its result loads in DONE.
module ex_stage_md #(
  parameter int XLEN          = 32,
  parameter int MUL_ITERATIVE = 0,
  parameter int FWD_EN        = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rd,
  input  logic [3:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_pc_src,
  input  logic            id_branch,
  input  logic            id_jal,
  input  logic            id_jalr,
  input  logic [2:0]      id_funct3,
  input  logic            id_md_en,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic [4:0]      exm_rd,
  input  logic            exm_reg_write,
  input  logic [XLEN-1:0] exm_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_req,
  output logic            take_branch,
  output logic [XLEN-1:0] branch_target,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_result,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic [1:0]      fsm_state
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_res, norm_res;
  logic [SHW-1:0]  shamt;
  logic            cond, br_active;

  // Forwarding: EX/MEM beats MEM/WB, x0 is never forwarded.
  always_comb begin
    fwd_rs1 = id_rs1_data;
    fwd_rs2 = id_rs2_data;
    if (FWD_EN != 0 && id_rs1 != 5'd0) begin
      if (exm_reg_write && exm_rd == id_rs1)     fwd_rs1 = exm_result;
      else if (wb_reg_write && wb_rd == id_rs1)  fwd_rs1 = wb_data;
    end
    if (FWD_EN != 0 && id_rs2 != 5'd0) begin
      if (exm_reg_write && exm_rd == id_rs2)     fwd_rs2 = exm_result;
      else if (wb_reg_write && wb_rd == id_rs2)  fwd_rs2 = wb_data;
    end
  end

  assign op_a  = id_pc_src ? id_pc : fwd_rs1;
  assign op_b  = id_alu_src ? id_imm : fwd_rs2;
  assign shamt = op_b[SHW-1:0];

  // Integer ALU.
  always_comb begin
    alu_res = '0;
    case (id_alu_op)
      4'd0:  alu_res = op_a + op_b;
      4'd1:  alu_res = op_a - op_b;
      4'd2:  alu_res = op_a << shamt;
      4'd3:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'd4:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'd5:  alu_res = op_a ^ op_b;
      4'd6:  alu_res = op_a >> shamt;
      4'd7:  alu_res = $unsigned($signed(op_a) >>> shamt);
      4'd8:  alu_res = op_a | op_b;
      4'd9:  alu_res = op_a & op_b;
      4'd10: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // Branch comparator, independent of the ALU operand muxes.
  always_comb begin
    cond = 1'b0;
    case (id_funct3)
      3'b000: cond = (fwd_rs1 == fwd_rs2);
      3'b001: cond = (fwd_rs1 != fwd_rs2);
      3'b100: cond = ($signed(fwd_rs1) < $signed(fwd_rs2));
      3'b101: cond = !($signed(fwd_rs1) < $signed(fwd_rs2));
      3'b110: cond = (fwd_rs1 < fwd_rs2);
      3'b111: cond = !(fwd_rs1 < fwd_rs2);
      default: cond = 1'b0;
    endcase
  end

  assign br_active     = !reset && in_valid && !flush && (state == IDLE);
  assign take_branch   = br_active && (id_jal || id_jalr || (id_branch && cond));
  assign branch_target = !take_branch ? '0 :
                         id_jalr ? ((fwd_rs1 + id_imm) & {{(XLEN-1){1'b1}}, 1'b0}) :
                         (id_pc + id_imm);

  // M-unit operand preparation: magnitudes plus sign-correction flags.
  logic            is_div, sgn_a, sgn_b, a_neg, b_neg, md_multi, div_special;
  logic [XLEN-1:0] mag_a, mag_b, special_res, mul_res_c;
  logic [2*XLEN-1:0] prod_c, prod_cs;
  always_comb begin
    is_div      = id_funct3[2];
    sgn_a       = is_div ? !id_funct3[0] : (id_funct3 == 3'b001 || id_funct3 == 3'b010);
    sgn_b       = is_div ? !id_funct3[0] : (id_funct3 == 3'b001);
    a_neg       = sgn_a && fwd_rs1[XLEN-1];
    b_neg       = sgn_b && fwd_rs2[XLEN-1];
    mag_a       = a_neg ? -fwd_rs1 : fwd_rs1;
    mag_b       = b_neg ? -fwd_rs2 : fwd_rs2;
    md_multi    = id_md_en && (is_div || MUL_ITERATIVE != 0);
    div_special = is_div && ((fwd_rs2 == '0) ||
                  (!id_funct3[0] && fwd_rs1 == {1'b1, {(XLEN-1){1'b0}}} && fwd_rs2 == '1));
    if (id_funct3[1]) special_res = (fwd_rs2 == '0) ? fwd_rs1 : '0;
    else              special_res = (fwd_rs2 == '0) ? '1 : fwd_rs1;
    prod_c    = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    prod_cs   = (a_neg ^ b_neg) ? -prod_c : prod_c;
    mul_res_c = (id_funct3 == 3'b000) ? prod_cs[XLEN-1:0] : prod_cs[2*XLEN-1:XLEN];
  end

  logic accept;
  assign accept    = (state == IDLE) && in_valid && !flush && md_multi;
  assign fsm_state = state;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  logic [CW-1:0]   count;
  logic [XLEN-1:0] acc_hi, acc_lo, opnd_b, spec_res, cap_rs2;
  logic [2:0]      md_f3;
  logic            md_qneg, md_rneg, md_special;
  logic [4:0]      cap_rd;
  logic            cap_reg_write, cap_mem_read, cap_mem_write, cap_mem_to_reg;

  // Next state and stall request.
  always_comb begin
    state_nxt = state;
    stall_req = 1'b0;
    case (state)
      IDLE: if (accept) begin
        stall_req = 1'b1;
        state_nxt = div_special ? DONE : BUSY;
      end
      BUSY: begin
        stall_req = !flush;
        if (flush)                  state_nxt = IDLE;
        else if (count == CW'(1))   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (reset) stall_req = 1'b0;
  end

  // One shift-add or restoring-divide step.
  logic [XLEN:0]   mul_sum, rsh;
  logic [XLEN-1:0] step_hi, step_lo, diff;
  logic            ge;
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    rsh     = {acc_hi, acc_lo[XLEN-1]};
    ge      = (rsh >= {1'b0, opnd_b});
    diff    = rsh[XLEN-1:0] - opnd_b;
    if (md_f3[2]) begin
      step_hi = ge ? diff : rsh[XLEN-1:0];
      step_lo = {acc_lo[XLEN-2:0], ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
  end

  // Iterative unit registers: capture at accept, iterate while BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0; acc_hi <= '0; acc_lo <= '0; opnd_b <= '0; spec_res <= '0;
      cap_rs2 <= '0; md_f3 <= '0; md_qneg <= 1'b0; md_rneg <= 1'b0;
      md_special <= 1'b0; cap_rd <= '0; cap_reg_write <= 1'b0;
      cap_mem_read <= 1'b0; cap_mem_write <= 1'b0; cap_mem_to_reg <= 1'b0;
    end else if (accept) begin
      count <= CW'(XLEN);
      acc_hi <= '0;
      acc_lo <= is_div ? mag_a : mag_b;
      opnd_b <= is_div ? mag_b : mag_a;
      spec_res <= special_res;
      md_special <= div_special;
      md_f3 <= id_funct3;
      md_qneg <= a_neg ^ b_neg;
      md_rneg <= a_neg;
      cap_rs2 <= fwd_rs2;
      cap_rd <= id_rd;
      cap_reg_write <= id_reg_write;
      cap_mem_read <= id_mem_read;
      cap_mem_write <= id_mem_write;
      cap_mem_to_reg <= id_mem_to_reg;
    end else if (state == BUSY) begin
      count <= count - CW'(1);
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

  // Final sign correction and result selection for the iterative unit.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rem, md_res;
  always_comb begin
    prod_s = md_qneg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo    = md_qneg ? -acc_lo : acc_lo;
    rem    = md_rneg ? -acc_hi : acc_hi;
    if (md_special)          md_res = spec_res;
    else if (md_f3[2])       md_res = md_f3[1] ? rem : quo;
    else if (md_f3 == 3'b0)  md_res = prod_s[XLEN-1:0];
    else                     md_res = prod_s[2*XLEN-1:XLEN];
  end

  assign norm_res = (id_jal || id_jalr) ? (id_pc + XLEN'(4)) :
                    id_md_en ? mul_res_c : alu_res;

  // EX/MEM register: iterative result in DONE, bubbles on stall/flush/empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0; ex_result <= '0; ex_rs2_data <= '0; ex_rd <= '0;
      ex_reg_write <= 1'b0; ex_mem_read <= 1'b0; ex_mem_write <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (!flush && state == DONE) begin
      ex_valid <= 1'b1; ex_result <= md_res; ex_rs2_data <= cap_rs2;
      ex_rd <= cap_rd; ex_reg_write <= cap_reg_write;
      ex_mem_read <= cap_mem_read; ex_mem_write <= cap_mem_write;
      ex_mem_to_reg <= cap_mem_to_reg;
    end else if (flush || stall_req || !in_valid || state != IDLE) begin
      ex_valid <= 1'b0; ex_reg_write <= 1'b0; ex_mem_read <= 1'b0;
      ex_mem_write <= 1'b0; ex_mem_to_reg <= 1'b0;
    end else begin
      ex_valid <= 1'b1; ex_result <= norm_res; ex_rs2_data <= fwd_rs2;
      ex_rd <= id_rd; ex_reg_write <= id_reg_write;
      ex_mem_read <= id_mem_read; ex_mem_write <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
    end
  end

endmodule
